rs232_rx: RTL and testbench

RS232_RX -- requirements
Module: rs232_rx

---
 rtl/rs232_rx.sv | 136 +++++++++++++
 tb/tb_rs232_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// rs232_rx: RS-232 receiver (idle=0, start=1, 8 data bits LSB first, stop=0)
// with a single-entry valid/ready output buffer, frame error and overrun pulses.
`default_nettype none

module rs232_rx #(
  parameter int baud = 9600,
  parameter int mhz  = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RS232_DCE_RXD,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned BIT_CLKS  = (mhz * 1_000_000) / baud + 1;
  localparam int unsigned HALF      = BIT_CLKS / 2;
  localparam logic [31:0] BIT_LAST  = 32'(BIT_CLKS - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  shift, shift_nx;
  logic        sync1, sync2;
  logic        line;
  logic        deliver;
  logic        ferr_nx;

  assign line = sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE;
      cnt   <= 32'd0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else begin
      sync1 <= RS232_DCE_RXD;
      sync2 <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    deliver  = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (line) begin
          state_nx = START;
          cnt_nx   = 32'd0;
        end
      end
      START: begin
        // Mid-start-bit check rejects short glitches on the line
        if (cnt == HALF_LAST) begin
          cnt_nx = 32'd0;
          if (line) begin
            state_nx = DATA;
            idx_nx   = 3'd0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          shift_nx[idx] = line;
          cnt_nx        = 32'd0;
          idx_nx        = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = 32'd0;
          state_nx = IDLE;
          if (!line) deliver = 1'b1;
          else       ferr_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output buffer runs independently of the FSM; a full buffer drops the new byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nx;
      overrun   <= 1'b0;
      if (deliver && (!rx_vld || rx_rdy)) begin
        rx_data <= shift;
        rx_vld  <= 1'b1;
      end else begin
        if (deliver) overrun <= 1'b1;
        if (rx_vld && rx_rdy) rx_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: scoreboard bench for rs232_rx at mhz=1, baud=100000 (11 clocks/bit).
`default_nettype none

module tb_rs232_rx;

  localparam int BITC = 11;
  localparam logic [1:0] EV_BYTE = 2'd0;
  localparam logic [1:0] EV_FERR = 2'd1;
  localparam logic [1:0] EV_OVR  = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd   = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic prev_vld  = 1'b0;
  logic prev_xfer = 1'b0;

  rs232_rx #(.baud(100000), .mhz(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .RS232_DCE_RXD(rxd),
    .rx_data      (rx_data),
    .rx_vld       (rx_vld),
    .rx_rdy       (rx_rdy),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    tick(BITC);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b1);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic accept_one();
    rx_rdy = 1'b1;
    tick(1);
    rx_rdy = 1'b0;
  endtask

  // Monitor: every byte presentation and error pulse is matched against the queue
  task automatic observe(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        errors++;
        $display("FAIL event_order: got kind %0d data %h, required kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_vld && (!prev_vld || prev_xfer)) observe(EV_BYTE, rx_data);
      if (frame_err) observe(EV_FERR, 8'h00);
      if (overrun)   observe(EV_OVR, 8'h00);
    end
    prev_vld  = rx_vld;
    prev_xfer = rx_vld && rx_rdy;
  end

  initial begin
    tick(3);
    check("reset_rx_data",   rx_data,          8'h00);
    check("reset_rx_vld",    {7'd0, rx_vld},   8'h00);
    check("reset_frame_err", {7'd0, frame_err},8'h00);
    check("reset_overrun",   {7'd0, overrun},  8'h00);
    check("reset_busy",      {7'd0, busy},     8'h00);
    reset = 1'b0;
    tick(5);

    // Valid frame held in the buffer, then a single-cycle accept
    expect_ev(EV_BYTE, 8'hA5);
    send_frame(8'hA5, 1'b0);
    rxd = 1'b0;
    tick(3);
    check("a5_vld",  {7'd0, rx_vld}, 8'h01);
    check("a5_data", rx_data,        8'hA5);
    accept_one();
    check("a5_vld_cleared", {7'd0, rx_vld}, 8'h00);
    tick(5);

    // Short pulse: START entered, then aborted at the half-bit check
    rxd = 1'b1;
    tick(3);
    rxd = 1'b0;
    check("glitch_busy_high", {7'd0, busy}, 8'h01);
    tick(10);
    check("glitch_busy_low", {7'd0, busy},   8'h00);
    check("glitch_no_vld",   {7'd0, rx_vld}, 8'h00);
    check("glitch_data_kept", rx_data,       8'hA5);
    tick(5);

    // Bad stop bit
    expect_ev(EV_FERR, 8'h00);
    send_frame(8'h5A, 1'b1);
    rxd = 1'b0;
    tick(20);
    check("ferr_no_vld", {7'd0, rx_vld}, 8'h00);
    check("ferr_idle",   {7'd0, busy},   8'h00);

    // Back-to-back frames into a full buffer
    expect_ev(EV_BYTE, 8'h3C);
    expect_ev(EV_OVR, 8'h00);
    send_frame(8'h3C, 1'b0);
    send_frame(8'hC3, 1'b0);
    rxd = 1'b0;
    tick(5);
    check("ovr_data_held", rx_data,        8'h3C);
    check("ovr_vld_held",  {7'd0, rx_vld}, 8'h01);
    accept_one();
    tick(5);

    // Reset in the middle of data bit 4 aborts the frame
    rxd = 1'b1;
    tick(BITC);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2));
    rxd = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    check("midreset_busy", {7'd0, busy},   8'h00);
    check("midreset_data", rx_data,        8'h00);
    reset = 1'b0;
    tick(20);
    check("midreset_no_vld", {7'd0, rx_vld}, 8'h00);
    expect_ev(EV_BYTE, 8'h81);
    send_frame(8'h81, 1'b0);
    rxd = 1'b0;
    tick(3);
    check("post_reset_data", rx_data,        8'h81);
    check("post_reset_vld",  {7'd0, rx_vld}, 8'h01);
    accept_one();
    tick(5);

    // Stream of frames with the consumer always ready
    rx_rdy = 1'b1;
    expect_ev(EV_BYTE, 8'h00);
    expect_ev(EV_BYTE, 8'hFF);
    expect_ev(EV_BYTE, 8'h55);
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    tick(20);
    rx_rdy = 1'b0;
    check("stream_vld_drained", {7'd0, rx_vld}, 8'h00);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
